// File: rtl/sram16_if.sv
`default_nettype none
// ============================================================================
// Module      : sram16_if
// Description : 16-bit async-SRAM pin bundle shared between an initiator
//               (master) and a responder (slave). The data bus is a resolved
//               net so either side may drive or release it.
//   sram_a     21  word address            (master -> slave)
//   sram_d     16  shared data bus         (bidirectional)
//   sram_we_n   1  write strobe, active low (master -> slave)
//   sram_ub_n   1  upper-byte lane enable  (master -> slave)
//   sram_lb_n   1  lower-byte lane enable  (master -> slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface sram16_if;
  logic [20:0] sram_a;
  wire  [15:0] sram_d;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  modport master (
    output sram_a,
    output sram_we_n,
    output sram_ub_n,
    output sram_lb_n,
    inout  sram_d
  );

  modport slave (
    input  sram_a,
    input  sram_we_n,
    input  sram_ub_n,
    input  sram_lb_n,
    inout  sram_d
  );
endinterface
`default_nettype wire

// File: rtl/sram16_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram16_responder
// Description : Async-SRAM responder backed by internal RAM. Serves reads with
//               one clock of latency, commits writes at the end of the strobe,
//               and keeps access statistics plus a sticky protocol-error flag.
// Ports       :
//   clk           in   system clock (shared with the initiator)
//   resetn        in   asynchronous active-low reset
//   bus           slave side of the SRAM pin bundle
//   wr_count      out  committed writes, saturating
//   rd_count      out  read accesses (address changes), saturating
//   last_wr_addr  out  address of the most recent committed write
//   busy          out  high while a write strobe is in progress
//   protocol_err  out  sticky: address or lanes changed mid-strobe
// Revision    : 1.0 - initial release
// ============================================================================
module sram16_responder #(
  parameter int          ADDR_BITS = 10,
  parameter logic [15:0] FILL      = 16'hDEAD
) (
  input  wire logic  clk,
  input  wire logic  resetn,
  sram16_if.slave    bus,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic [20:0] last_wr_addr,
  output logic        busy,
  output logic        protocol_err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WR_ACTIVE = 2'd1;
  localparam logic [1:0] S_WR_COMMIT = 2'd2;

  logic [15:0] mem [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [15:0] rd_q, rd_d;
  logic [20:0] addr_q, addr_d;
  logic [1:0]  lanes_q, lanes_d;      // {ub_n, lb_n} captured at strobe start
  logic [15:0] data_q, data_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [20:0] last_wr_addr_q, last_wr_addr_d;
  logic        busy_q, busy_d;
  logic        perr_q, perr_d;
  logic [20:0] prev_a_q, prev_a_d;    // address seen at the previous edge
  logic        first_q, first_d;      // no read counted yet since reset

  logic                 a_in_range;
  logic                 latched_in_range;
  logic [ADDR_BITS-1:0] a_idx;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 lane_any;
  logic                 commit_ok;
  logic                 drive_en;

  assign a_in_range       = (bus.sram_a >> ADDR_BITS) == 21'd0;
  assign latched_in_range = (addr_q >> ADDR_BITS) == 21'd0;
  assign a_idx            = bus.sram_a[ADDR_BITS-1:0];
  assign w_idx            = addr_q[ADDR_BITS-1:0];
  assign lane_any         = !(bus.sram_ub_n && bus.sram_lb_n);
  assign commit_ok        = (state_q == S_WR_COMMIT) && latched_in_range && (lanes_q != 2'b11);

  // Drive is gated directly by we_n so the bus is released in the same cycle
  // the initiator starts driving write data.
  assign drive_en = resetn && bus.sram_we_n;
  assign bus.sram_d[15:8] = (drive_en && !bus.sram_ub_n) ? rd_q[15:8] : 8'hzz;
  assign bus.sram_d[7:0]  = (drive_en && !bus.sram_lb_n) ? rd_q[7:0]  : 8'hzz;

  always_comb begin
    state_d        = state_q;
    rd_d           = a_in_range ? mem[a_idx] : FILL;
    addr_d         = addr_q;
    lanes_d        = lanes_q;
    data_d         = data_q;
    wr_count_d     = wr_count_q;
    rd_count_d     = rd_count_q;
    last_wr_addr_d = last_wr_addr_q;
    perr_d         = perr_q;
    prev_a_d       = bus.sram_a;
    first_d        = first_q;

    case (state_q)
      S_IDLE: begin
        if (!bus.sram_we_n) begin
          state_d = S_WR_ACTIVE;
          addr_d  = bus.sram_a;
          lanes_d = {bus.sram_ub_n, bus.sram_lb_n};
          data_d  = bus.sram_d;
        end else if (lane_any && (first_q || (bus.sram_a != prev_a_q))) begin
          rd_count_d = (rd_count_q == 16'hFFFF) ? rd_count_q : rd_count_q + 16'd1;
          first_d    = 1'b0;
        end
      end
      S_WR_ACTIVE: begin
        if (!bus.sram_we_n) begin
          // Last sampled data wins; address and lanes stay as first latched.
          data_d = bus.sram_d;
          if ((bus.sram_a != addr_q) || ({bus.sram_ub_n, bus.sram_lb_n} != lanes_q)) begin
            perr_d = 1'b1;
          end
        end else begin
          state_d = S_WR_COMMIT;
        end
      end
      S_WR_COMMIT: begin
        if (commit_ok) begin
          wr_count_d     = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
          last_wr_addr_d = addr_q;
        end
        if (!bus.sram_we_n) begin
          state_d = S_WR_ACTIVE;
          addr_d  = bus.sram_a;
          lanes_d = {bus.sram_ub_n, bus.sram_lb_n};
          data_d  = bus.sram_d;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WR_ACTIVE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      rd_q           <= 16'd0;
      addr_q         <= 21'd0;
      lanes_q        <= 2'b00;
      data_q         <= 16'd0;
      wr_count_q     <= 16'd0;
      rd_count_q     <= 16'd0;
      last_wr_addr_q <= 21'd0;
      busy_q         <= 1'b0;
      perr_q         <= 1'b0;
      prev_a_q       <= 21'd0;
      first_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      rd_q           <= rd_d;
      addr_q         <= addr_d;
      lanes_q        <= lanes_d;
      data_q         <= data_d;
      wr_count_q     <= wr_count_d;
      rd_count_q     <= rd_count_d;
      last_wr_addr_q <= last_wr_addr_d;
      busy_q         <= busy_d;
      perr_q         <= perr_d;
      prev_a_q       <= prev_a_d;
      first_q        <= first_d;
    end
  end

  // Array is not reset; only enabled lanes are written during the commit cycle.
  always_ff @(posedge clk) begin
    if (commit_ok) begin
      if (!lanes_q[1]) mem[w_idx][15:8] <= data_q[15:8];
      if (!lanes_q[0]) mem[w_idx][7:0]  <= data_q[7:0];
    end
  end

  assign wr_count     = wr_count_q;
  assign rd_count     = rd_count_q;
  assign last_wr_addr = last_wr_addr_q;
  assign busy         = busy_q;
  assign protocol_err = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_sram16_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram16_responder
// Description : Self-checking bench for sram16_responder. A word/byte-level
//               model of the memory and its statistics predicts every value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram16_responder;
  localparam int          ADDR_BITS = 10;
  localparam logic [15:0] FILL      = 16'hDEAD;
  localparam int          WORDS     = 1 << ADDR_BITS;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram16_if sif();

  logic        tb_oe_hi = 1'b0;
  logic        tb_oe_lo = 1'b0;
  logic [15:0] tb_d = 16'd0;
  assign sif.sram_d[15:8] = tb_oe_hi ? tb_d[15:8] : 8'hzz;
  assign sif.sram_d[7:0]  = tb_oe_lo ? tb_d[7:0]  : 8'hzz;

  logic [15:0] wr_count, rd_count;
  logic [20:0] last_wr_addr;
  logic        busy, protocol_err;

  sram16_responder #(.ADDR_BITS(ADDR_BITS), .FILL(FILL)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (sif),
    .wr_count     (wr_count),
    .rd_count     (rd_count),
    .last_wr_addr (last_wr_addr),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  // Reference model
  logic [15:0] m_mem [WORDS];
  bit          m_known_hi [WORDS];
  bit          m_known_lo [WORDS];
  int          m_wr = 0;
  int          m_rd = 0;
  logic [20:0] m_last = 21'd0;
  logic [20:0] m_prev = 21'd0;
  bit          m_first = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [20:0] a);
    return int'(a) < WORDS;
  endfunction

  function automatic logic [15:0] exp_word(input logic [20:0] a);
    if (!in_range(a)) return FILL;
    return m_mem[a[ADDR_BITS-1:0]];
  endfunction

  function automatic bit known_hi(input logic [20:0] a);
    return !in_range(a) || m_known_hi[a[ADDR_BITS-1:0]];
  endfunction

  function automatic bit known_lo(input logic [20:0] a);
    return !in_range(a) || m_known_lo[a[ADDR_BITS-1:0]];
  endfunction

  // A read access is counted when an idle, read-mode edge sees a new address.
  task automatic model_read_edge(input logic [20:0] a, input logic ub, input logic lb);
    if (!(ub && lb) && (m_first || a != m_prev)) begin
      if (m_rd < 65535) m_rd++;
      m_first = 1'b0;
    end
    m_prev = a;
  endtask

  task automatic model_commit(input logic [20:0] a, input logic [15:0] d,
                              input logic ub, input logic lb);
    if (in_range(a) && !(ub && lb)) begin
      if (!ub) begin
        m_mem[a[ADDR_BITS-1:0]][15:8] = d[15:8];
        m_known_hi[a[ADDR_BITS-1:0]] = 1'b1;
      end
      if (!lb) begin
        m_mem[a[ADDR_BITS-1:0]][7:0] = d[7:0];
        m_known_lo[a[ADDR_BITS-1:0]] = 1'b1;
      end
      if (m_wr < 65535) m_wr++;
      m_last = a;
    end
    m_prev = a;
  endtask

  task automatic do_write(input logic [20:0] a, input logic [15:0] d_first,
                          input logic [15:0] d_last, input logic ub, input logic lb,
                          input int width, input string tag);
    int busy_seen;
    busy_seen = 0;
    sif.sram_a = a; sif.sram_ub_n = ub; sif.sram_lb_n = lb; sif.sram_we_n = 1'b0;
    tb_d = d_first; tb_oe_hi = 1'b1; tb_oe_lo = 1'b1;
    for (int i = 0; i < width; i++) begin
      if (i == width - 1) tb_d = d_last;
      tick();
      if (busy === 1'b1) busy_seen++;
    end
    sif.sram_we_n = 1'b1; tb_oe_hi = 1'b0; tb_oe_lo = 1'b0;
    tick(); if (busy === 1'b1) busy_seen++;
    tick(); if (busy === 1'b1) busy_seen++;
    model_commit(a, d_last, ub, lb);
    chk({tag, "_busy_cycles"}, busy_seen, width);
    chk({tag, "_wr_count"}, wr_count, m_wr);
    chk({tag, "_last_wr_addr"}, last_wr_addr, m_last);
  endtask

  // Disabled lanes carry a bench probe value, which must read back intact
  // when the responder has released that lane.
  task automatic do_read(input logic [20:0] a, input logic ub, input logic lb,
                         input string tag);
    logic [15:0] e;
    e = exp_word(a);
    sif.sram_a = a; sif.sram_ub_n = ub; sif.sram_lb_n = lb; sif.sram_we_n = 1'b1;
    tb_d = 16'hC3C3; tb_oe_hi = ub; tb_oe_lo = lb;
    tick(); model_read_edge(a, ub, lb);
    tick(); model_read_edge(a, ub, lb);
    if (!ub) begin
      if (known_hi(a)) chk({tag, "_d_hi"}, sif.sram_d[15:8], e[15:8]);
    end else begin
      chk({tag, "_hi_released"}, sif.sram_d[15:8], 8'hC3);
    end
    if (!lb) begin
      if (known_lo(a)) chk({tag, "_d_lo"}, sif.sram_d[7:0], e[7:0]);
    end else begin
      chk({tag, "_lo_released"}, sif.sram_d[7:0], 8'hC3);
    end
    chk({tag, "_rd_count"}, rd_count, m_rd);
    tb_oe_hi = 1'b0; tb_oe_lo = 1'b0;
  endtask

  initial begin
    logic [20:0] ra;
    logic [1:0]  rl;
    sif.sram_a = 21'd0; sif.sram_we_n = 1'b1; sif.sram_ub_n = 1'b0; sif.sram_lb_n = 1'b0;
    #1;
    chk("reset_wr_count", wr_count, 0);
    chk("reset_rd_count", rd_count, 0);
    chk("reset_last_wr", last_wr_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_perr", protocol_err, 0);
    repeat (2) tick();
    resetn = 1'b1;

    // Fast one-cycle strobe
    do_write(21'h000003, 16'h5555, 16'h5555, 1'b0, 1'b0, 1, "fast");
    chk("fast_wr_is_1", wr_count, 16'd1);
    chk("fast_last_is_3", last_wr_addr, 21'h000003);
    do_read(21'h000003, 1'b0, 1'b0, "fast_rd");
    chk("fast_rd_5555", sif.sram_d, 16'h5555);

    // Fill a small pool so later random reads have known contents
    for (int i = 0; i < 16; i++)
      do_write(21'(i), 16'($urandom), 16'($urandom), 1'b0, 1'b0, $urandom_range(1, 3), "pool");

    // Byte lanes
    do_write(21'd7, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 2, "lane_full");
    do_write(21'd7, 16'h1234, 16'h1234, 1'b1, 1'b0, 1, "lane_lo");
    do_read(21'd7, 1'b0, 1'b0, "lane_rd");
    chk("lane_rd_ff34", sif.sram_d, 16'hFF34);
    do_read(21'd8, 1'b0, 1'b0, "lane_other");
    do_read(21'd7, 1'b0, 1'b1, "lane_hi_only");

    // Slow strobe, data updated on the last low cycle
    do_write(21'd10, 16'hAAAA, 16'hBBBB, 1'b0, 1'b0, 4, "slow");
    do_read(21'd10, 1'b0, 1'b0, "slow_rd");
    chk("slow_rd_bbbb", sif.sram_d, 16'hBBBB);

    // Out of range
    do_write(21'h000400, 16'h1111, 16'h1111, 1'b0, 1'b0, 1, "oor");
    do_read(21'h000400, 1'b0, 1'b0, "oor_rd");
    chk("oor_rd_dead", sif.sram_d, FILL);
    do_read(21'h000000, 1'b0, 1'b0, "oor_addr0");

    // Protocol error: address moves mid-strobe
    sif.sram_a = 21'd5; sif.sram_ub_n = 1'b0; sif.sram_lb_n = 1'b0; sif.sram_we_n = 1'b0;
    tb_d = 16'h0F0F; tb_oe_hi = 1'b1; tb_oe_lo = 1'b1;
    tick();
    sif.sram_a = 21'd6;
    tick();
    sif.sram_we_n = 1'b1; tb_oe_hi = 1'b0; tb_oe_lo = 1'b0;
    tick(); tick();
    model_commit(21'd5, 16'h0F0F, 1'b0, 1'b0);
    m_prev = 21'd6;
    chk("perr_set", protocol_err, 1);
    chk("perr_last_wr", last_wr_addr, 21'd5);
    do_read(21'd5, 1'b0, 1'b0, "perr_orig");
    chk("perr_orig_0f0f", sif.sram_d, 16'h0F0F);
    do_read(21'd6, 1'b0, 1'b0, "perr_moved");

    // Randomized mix of writes and reads
    for (int n = 0; n < 150; n++) begin
      ra = ($urandom_range(0, 5) == 0) ? (21'($urandom) | 21'h000400)
                                       : 21'($urandom_range(0, 15));
      rl = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        do_write(ra, 16'($urandom), 16'($urandom), rl[1], rl[0], $urandom_range(1, 4), "rnd_wr");
      else
        do_read(ra, rl[1], rl[0], "rnd_rd");
    end
    chk("perr_sticky", protocol_err, 1);

    // Asynchronous reset in the middle of a strobe
    sif.sram_a = 21'd9; sif.sram_ub_n = 1'b0; sif.sram_lb_n = 1'b0; sif.sram_we_n = 1'b0;
    tb_d = 16'h7777; tb_oe_hi = 1'b1; tb_oe_lo = 1'b1;
    tick();
    chk("rst_pre_busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_last_wr", last_wr_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", protocol_err, 0);
    m_wr = 0; m_rd = 0; m_last = 21'd0; m_first = 1'b1;
    sif.sram_we_n = 1'b1; tb_d = 16'h3CC3;
    #1;
    chk("rst_bus_released", sif.sram_d, 16'h3CC3);
    sif.sram_we_n = 1'b0; tb_d = 16'h8888;
    tick();
    resetn = 1'b1;
    tick();
    sif.sram_we_n = 1'b1; tb_oe_hi = 1'b0; tb_oe_lo = 1'b0;
    tick(); tick();
    model_commit(21'd9, 16'h8888, 1'b0, 1'b0);
    chk("rst_new_wr_count", wr_count, m_wr);
    chk("rst_new_last_wr", last_wr_addr, 21'd9);
    do_read(21'd9, 1'b0, 1'b0, "rst_rd");

    // Read-count saturation
    sif.sram_we_n = 1'b1; sif.sram_ub_n = 1'b0; sif.sram_lb_n = 1'b0;
    for (int i = 0; i < 66000; i++) begin
      sif.sram_a = (i % 2 == 0) ? 21'd1 : 21'd2;
      tick();
      model_read_edge(sif.sram_a, 1'b0, 1'b0);
    end
    chk("rd_sat_model", rd_count, m_rd);
    chk("rd_sat_ffff", rd_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
